// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way WIDTH-bit selector registered into a valid/ready stage.
// Optional skid register enabled by defining MUX_PIPE_SKID_EN; without it the
// stage holds one entry and in_ready is combinational from out_ready.
module mux_n_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   din,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     dout,
    output logic [SELW-1:0]      out_sel
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_m_data;
    logic [SELW-1:0]    r_m_sel;
    logic [WIDTH-1:0]   w_mux;
    logic               w_acc;
    logic               w_emit;

    // Select din[sel]; indices at or beyond N read as zero.
    always_comb begin
        w_mux = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) w_mux = din[k*WIDTH +: WIDTH];
        end
    end

    assign out_valid = (r_state != ST_EMPTY);
    assign dout      = r_m_data;
    assign out_sel   = r_m_sel;
    assign w_acc     = in_valid && in_ready;
    assign w_emit    = out_valid && out_ready;

`ifdef MUX_PIPE_SKID_EN
    logic [WIDTH-1:0]   r_s_data;
    logic [SELW-1:0]    r_s_sel;
    logic               r_in_ready;

    // in_ready is a plain flop so out_ready never reaches it combinationally.
    assign in_ready = r_in_ready;

    // Occupancy FSM with main/skid registers; flush wins over accept/emit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_m_data   <= '0;
            r_m_sel    <= '0;
            r_s_data   <= '0;
            r_s_sel    <= '0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_m_data <= w_mux;
                        r_m_sel  <= sel;
                        r_state  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({w_acc, w_emit})
                        2'b11: begin
                            r_m_data <= w_mux;
                            r_m_sel  <= sel;
                        end
                        2'b01: r_state <= ST_EMPTY;
                        2'b10: begin
                            // Head still held downstream: park new entry in skid.
                            r_s_data   <= w_mux;
                            r_s_sel    <= sel;
                            r_state    <= ST_TWO;
                            r_in_ready <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_TWO: begin
                    if (w_emit) begin
                        r_m_data   <= r_s_data;
                        r_m_sel    <= r_s_sel;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end
`else
    // Single entry: accept when empty or when the held entry leaves this cycle.
    assign in_ready = !out_valid || out_ready;

    // Occupancy FSM with one register; flush wins over accept/emit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_m_data <= '0;
            r_m_sel  <= '0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY, ST_ONE: begin
                    if (w_acc) begin
                        r_m_data <= w_mux;
                        r_m_sel  <= sel;
                        r_state  <= ST_ONE;
                    end else if (w_emit) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end
`endif

endmodule
